// File: rtl/mmind_game_ctrl_if.sv
// Signal bundle between the Mastermind game sequencer and its surroundings:
// button pulses and code-register contents in, register enables and score/status out.
interface mmind_game_ctrl_if #(
  parameter int TRY_W = 4
);
  logic             start;
  logic             submit;
  logic             secret_en;
  logic             guess_en;
  logic [7:0]       secret_q;
  logic [7:0]       guess_q;
  logic [2:0]       exact;
  logic [2:0]       partial;
  logic             score_valid;
  logic [TRY_W-1:0] tries;
  logic             busy;
  logic             win;
  logic             lose;

  modport master (
    output start, submit, secret_q, guess_q,
    input  secret_en, guess_en, exact, partial, score_valid, tries, busy, win, lose
  );

  modport slave (
    input  start, submit, secret_q, guess_q,
    output secret_en, guess_en, exact, partial, score_valid, tries, busy, win, lose
  );
endinterface

// File: rtl/mmind_game_ctrl.sv
// Mastermind game sequencer: loads the secret, latches guesses, scores each guess
// one colour/peg per cycle over four cycles, and tracks tries and win/lose.
//
// state | meaning
// IDLE  | power-up, waiting for start
// LOAD  | secret register captures switches
// GUESS | waiting for submit
// LATCH | guess register captures switches
// SCORE | four-cycle peg/colour accumulation
// CHECK | score presented, decide win/lose/continue
// WIN   | game won, results held
// LOSE  | tries exhausted, results held
module mmind_game_ctrl #(
  parameter int MAX_TRIES = 8,
  parameter int TRY_W     = 4
) (
  input logic               clk,
  input logic               reset,
  mmind_game_ctrl_if.slave  gif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GUESS = 3'd2,
    LATCH = 3'd3,
    SCORE = 3'd4,
    CHECK = 3'd5,
    WIN   = 3'd6,
    LOSE  = 3'd7
  } state_t;

  localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);

  state_t           state, state_nx;
  logic [1:0]       score_cnt;
  logic [1:0]       idx;
  logic [2:0]       ex_acc, m_acc;
  logic [2:0]       ex_sum, m_sum;
  logic [2:0]       cnt_s, cnt_g;
  logic             peg_hit;
  logic [2:0]       exact_r, partial_r;
  logic [TRY_W-1:0] tries_r;
  logic             score_valid_r;

  function automatic logic [2:0] colour_count(input logic [7:0] code, input logic [1:0] colour);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++)
      n = n + {2'b00, code[2*i +: 2] == colour};
    return n;
  endfunction

  // score_cnt runs 3..0, so idx = 3 - score_cnt walks pegs/colours 0..3
  assign idx = ~score_cnt;

  always_comb begin
    cnt_s   = colour_count(gif.secret_q, idx);
    cnt_g   = colour_count(gif.guess_q, idx);
    peg_hit = gif.secret_q[{idx, 1'b0} +: 2] == gif.guess_q[{idx, 1'b0} +: 2];
    ex_sum  = ex_acc + {2'b00, peg_hit};
    m_sum   = m_acc + ((cnt_s < cnt_g) ? cnt_s : cnt_g);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (gif.start) state_nx = LOAD;
      LOAD:  state_nx = GUESS;
      GUESS: if (gif.submit) state_nx = LATCH;
      LATCH: state_nx = SCORE;
      SCORE: if (score_cnt == 2'd0) state_nx = CHECK;
      CHECK: begin
        if (exact_r == 3'd4)          state_nx = WIN;
        else if (tries_r == TRIES_MAX) state_nx = LOSE;
        else                          state_nx = GUESS;
      end
      WIN, LOSE: if (gif.start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // Results are registered on the last SCORE edge so they are already valid
  // during CHECK, alongside score_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_cnt     <= '0;
      ex_acc        <= '0;
      m_acc         <= '0;
      exact_r       <= '0;
      partial_r     <= '0;
      tries_r       <= '0;
      score_valid_r <= 1'b0;
    end else begin
      score_valid_r <= 1'b0;
      unique case (state)
        LOAD: begin
          exact_r   <= '0;
          partial_r <= '0;
          tries_r   <= '0;
        end
        LATCH: begin
          score_cnt <= 2'd3;
          ex_acc    <= '0;
          m_acc     <= '0;
        end
        SCORE: begin
          score_cnt <= score_cnt - 2'd1;
          ex_acc    <= ex_sum;
          m_acc     <= m_sum;
          if (score_cnt == 2'd0) begin
            score_valid_r <= 1'b1;
            exact_r       <= ex_sum;
            partial_r     <= m_sum - ex_sum;
            if (tries_r != TRIES_MAX) tries_r <= tries_r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gif.secret_en   = (state == LOAD);
  assign gif.guess_en    = (state == LATCH);
  assign gif.busy        = (state == LOAD) || (state == LATCH) || (state == SCORE) || (state == CHECK);
  assign gif.win         = (state == WIN);
  assign gif.lose        = (state == LOSE);
  assign gif.score_valid = score_valid_r;
  assign gif.exact       = exact_r;
  assign gif.partial     = partial_r;
  assign gif.tries       = tries_r;

endmodule

// File: tb/tb_mmind_game_ctrl.sv
// Self-checking bench for mmind_game_ctrl: a timeline model of the game predicts
// every output each cycle, and directed games check literal scores and latencies.
module tb_mmind_game_ctrl;
  localparam int MAX = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] secret_sw, guess_sw;
  logic [7:0] secret_reg = '0;
  logic [7:0] guess_reg  = '0;
  int         tests = 0;
  int         fails = 0;

  mmind_game_ctrl_if #(.TRY_W(4)) gif ();

  mmind_game_ctrl #(.MAX_TRIES(MAX), .TRY_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  always #5 clk = ~clk;

  // reg8e stand-ins owned by the surrounding top level
  always @(posedge clk) begin
    if (gif.secret_en) secret_reg <= secret_sw;
    if (gif.guess_en)  guess_reg  <= guess_sw;
  end
  assign gif.secret_q = secret_reg;
  assign gif.guess_q  = guess_reg;

  logic [15:0] act_vec;
  assign act_vec = {gif.secret_en, gif.guess_en, gif.busy, gif.score_valid, gif.win, gif.lose,
                    gif.exact, gif.partial, gif.tries};

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void score(input logic [7:0] s, input logic [7:0] g, output int ex, output int pa);
    int cs[4];
    int cg[4];
    int m;
    int ps, pg;
    ex = 0;
    m  = 0;
    for (int c = 0; c < 4; c++) begin
      cs[c] = 0;
      cg[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      ps = int'(s[2*i +: 2]);
      pg = int'(g[2*i +: 2]);
      if (ps == pg) ex++;
      cs[ps]++;
      cg[pg]++;
    end
    for (int c = 0; c < 4; c++) m += (cs[c] < cg[c]) ? cs[c] : cg[c];
    pa = m - ex;
  endfunction

  // Timeline model: acceptance of start/submit schedules the cycles at which
  // each visible effect must appear.
  int n = 0;
  int load_c, latch_c, res_c, clr_c, ready_c, over_c;
  bit active, over, won;
  int m_ex, m_pa, m_tr;

  task automatic model_reset();
    active = 0; over = 0; won = 0;
    load_c = -100; latch_c = -100; res_c = -100; clr_c = -100; ready_c = -100; over_c = -100;
    m_ex = 0; m_pa = 0; m_tr = 0;
  endtask

  initial begin
    logic [15:0] exp_vec;
    logic        e_se, e_ge, e_busy, e_val, e_win, e_lose;
    int          ex, pa;
    model_reset();
    forever begin
      @(negedge clk);
      n++;
      if (!reset) begin
        model_reset();
        exp_vec = '0;
      end else begin
        if (n == clr_c) begin
          m_ex = 0; m_pa = 0; m_tr = 0;
        end
        if (n == res_c) begin
          score(secret_reg, guess_reg, ex, pa);
          m_ex = ex;
          m_pa = pa;
          if (m_tr < MAX) m_tr++;
          if (ex == 4) begin
            over = 1; won = 1; over_c = n + 1;
          end else if (m_tr == MAX) begin
            over = 1; won = 0; over_c = n + 1;
          end else begin
            ready_c = n + 1;
          end
        end
        e_se   = (n == load_c);
        e_ge   = (n == latch_c);
        e_val  = (n == res_c);
        e_busy = e_se || (n >= latch_c && n <= res_c);
        e_win  = over && won && n >= over_c;
        e_lose = over && !won && n >= over_c;
        exp_vec = {e_se, e_ge, e_busy, e_val, e_win, e_lose, 3'(m_ex), 3'(m_pa), 4'(m_tr)};
      end
      chk("cycle_outputs", int'(act_vec), int'(exp_vec));
      if (reset) begin
        if (gif.start && (!active || (over && n >= over_c))) begin
          active = 1; over = 0; won = 0;
          load_c = n + 1; clr_c = n + 2; ready_c = n + 2;
          latch_c = -100; res_c = -100;
        end else if (gif.submit && active && !over && n >= ready_c) begin
          latch_c = n + 1;
          res_c   = n + 6;
          ready_c = n + 1000000;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (gif.score_valid) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic do_start(input logic [7:0] sec);
    secret_sw = sec;
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    tick();
  endtask

  task automatic do_guess(input logic [7:0] g, input int ex, input int pa, input int tr, input string nm);
    int lat;
    guess_sw   = g;
    gif.submit = 1'b1;
    tick();
    gif.submit = 1'b0;
    wait_valid(lat);
    chk({nm, "_latency"}, lat, 6);
    chk({nm, "_exact"}, int'(gif.exact), ex);
    chk({nm, "_partial"}, int'(gif.partial), pa);
    chk({nm, "_tries"}, int'(gif.tries), tr);
    tick();
  endtask

  initial begin
    int ex, pa, lat, cnt;
    reset = 1'b0;
    gif.start = 1'b0;
    gif.submit = 1'b0;
    secret_sw = '0;
    guess_sw = '0;

    score(8'h1B, 8'h1B, ex, pa); chk("model_1b_1b_ex", ex, 4); chk("model_1b_1b_pa", pa, 0);
    score(8'h1B, 8'hE4, ex, pa); chk("model_1b_e4_ex", ex, 0); chk("model_1b_e4_pa", pa, 4);
    score(8'h1B, 8'h1E, ex, pa); chk("model_1b_1e_ex", ex, 2); chk("model_1b_1e_pa", pa, 2);
    score(8'h00, 8'h55, ex, pa); chk("model_00_55_ex", ex, 0); chk("model_00_55_pa", pa, 0);

    tick(); tick();
    chk("reset_outputs", int'(act_vec), 0);
    reset = 1'b1;
    tick();

    do_start(8'h1B);
    do_guess(8'h1B, 4, 0, 1, "win_first");
    chk("win_first_win", int'(gif.win), 1);
    chk("win_first_busy", int'(gif.busy), 0);

    // all-wrong game ending in LOSE
    do_start(8'h00);
    do_guess(8'h55, 0, 0, 1, "lose_g1");
    chk("lose_g1_in_guess", int'({gif.win, gif.lose, gif.busy}), 0);
    do_guess(8'h1B, 1, 0, 2, "lose_g2");
    do_guess(8'h05, 2, 0, 3, "lose_g3");
    do_guess(8'h01, 3, 0, 4, "lose_g4");
    do_guess(8'hFF, 0, 0, 5, "lose_g5");
    do_guess(8'hAA, 0, 0, 6, "lose_g6");
    do_guess(8'h50, 2, 0, 7, "lose_g7");
    do_guess(8'h40, 3, 0, 8, "lose_g8");
    chk("lose_flag", int'(gif.lose), 1);
    chk("lose_no_win", int'(gif.win), 0);
    guess_sw = 8'h1B;
    gif.submit = 1'b1;
    tick();
    gif.submit = 1'b0;
    cnt = 0;
    repeat (8) begin
      if (gif.guess_en) cnt++;
      tick();
    end
    chk("ninth_submit_guess_en", cnt, 0);
    chk("ninth_submit_tries", int'(gif.tries), 8);

    // game won on the final try, with ignored start/submit and a held submit
    do_start(8'h1B);
    do_guess(8'hE4, 0, 4, 1, "fin_g1");
    chk("fin_g1_in_guess", int'({gif.win, gif.lose, gif.busy}), 0);
    do_guess(8'h1E, 2, 2, 2, "fin_g2");
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    cnt = 0;
    repeat (4) begin
      if (gif.secret_en) cnt++;
      tick();
    end
    chk("start_in_guess_secret_en", cnt, 0);
    chk("start_in_guess_exact", int'(gif.exact), 2);
    guess_sw = 8'h27;
    gif.submit = 1'b1;
    tick();
    gif.submit = 1'b0;
    tick();
    gif.submit = 1'b1;
    tick();
    gif.submit = 1'b0;
    wait_valid(lat);
    chk("submit_in_score_latency", lat, 4);
    chk("submit_in_score_exact", int'(gif.exact), 2);
    chk("submit_in_score_partial", int'(gif.partial), 2);
    chk("submit_in_score_tries", int'(gif.tries), 3);
    tick();
    guess_sw = 8'hE4;
    gif.submit = 1'b1;
    tick();
    wait_valid(lat);
    chk("held_first_latency", lat, 6);
    chk("held_first_tries", int'(gif.tries), 4);
    tick();
    wait_valid(lat);
    gif.submit = 1'b0;
    chk("held_refire_latency", lat, 7);
    chk("held_refire_tries", int'(gif.tries), 5);
    chk("held_refire_partial", int'(gif.partial), 4);
    tick();
    do_guess(8'hE4, 0, 4, 6, "fin_g6");
    do_guess(8'hE4, 0, 4, 7, "fin_g7");
    do_guess(8'h1B, 4, 0, 8, "fin_g8");
    chk("final_try_win", int'(gif.win), 1);
    chk("final_try_no_lose", int'(gif.lose), 0);

    // reset in the middle of scoring
    do_start(8'h1B);
    guess_sw = 8'hE4;
    gif.submit = 1'b1;
    tick();
    gif.submit = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_mid_score_outputs", int'(act_vec), 0);
    tick();
    tick();
    reset = 1'b1;
    guess_sw = 8'h1B;
    gif.submit = 1'b1;
    tick();
    gif.submit = 1'b0;
    cnt = 0;
    repeat (8) begin
      if (gif.guess_en || gif.score_valid) cnt++;
      tick();
    end
    chk("submit_after_reset_ignored", cnt, 0);
    do_start(8'h1B);
    do_guess(8'h1E, 2, 2, 1, "after_reset");
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
